// File: rtl/gumnut_data_mem_responder_if.sv
// rtl/gumnut_data_mem_responder_if.sv - Gumnut data-port Wishbone-classic bus bundle
interface gumnut_data_mem_responder_if #(
    parameter int ADDR_W = 8
);
    logic              data_cyc_i;
    logic              data_stb_i;
    logic              data_we_i;
    logic [ADDR_W-1:0] data_adr_i;
    logic [7:0]        data_dat_i;
    logic [7:0]        data_dat_o;
    logic              data_ack_o;

    modport master (
        output data_cyc_i,
        output data_stb_i,
        output data_we_i,
        output data_adr_i,
        output data_dat_i,
        input  data_dat_o,
        input  data_ack_o
    );

    modport slave (
        input  data_cyc_i,
        input  data_stb_i,
        input  data_we_i,
        input  data_adr_i,
        input  data_dat_i,
        output data_dat_o,
        output data_ack_o
    );
endinterface

// File: rtl/gumnut_data_mem_responder.sv
// rtl/gumnut_data_mem_responder.sv - Wishbone-classic data RAM responder with programmable wait states
module gumnut_data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    gumnut_data_mem_responder_if.slave   bus
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("gumnut_data_mem_responder: WAIT_STATES must be within 0..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic              we_q, we_d;
    logic [7:0]        wdat_q, wdat_d;
    logic              ack_q, ack_d;
    logic [7:0]        rdat_q, rdat_d;

    logic [7:0]        mem [DEPTH];
    logic              req;
    logic              enter_ack;
    logic              mem_we;

    always_comb begin
        req       = bus.data_cyc_i & bus.data_stb_i;
        state_d   = state_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        we_d      = we_q;
        wdat_d    = wdat_q;
        enter_ack = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    adr_d  = bus.data_adr_i;
                    we_d   = bus.data_we_i;
                    wdat_d = bus.data_dat_i;
                    cnt_d  = WAIT_LOAD;
                    if (WAIT_STATES == 0) begin
                        state_d   = ST_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A master that drops cyc/stb mid-wait abandons the access entirely.
                if (!req) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d   = ST_ACK;
                        enter_ack = 1'b1;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ack_d = enter_ack;

        // Commit and read both use the captured request, never the live bus.
        mem_we = enter_ack & we_d & ~rst_i;
        rdat_d = rdat_q;
        if (enter_ack && !we_d) begin
            rdat_d = mem[adr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= 8'h00;
            ack_q   <= 1'b0;
            rdat_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            ack_q   <= ack_d;
            rdat_q  <= rdat_d;
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[adr_d] <= wdat_d;
        end
    end

    assign bus.data_ack_o = ack_q;
    assign bus.data_dat_o = rdat_q;

    ack_single_cycle: assert property (@(posedge clk_i) disable iff (rst_i)
        ack_q |=> !ack_q);

    ack_only_in_ack_state: assert property (@(posedge clk_i) disable iff (rst_i)
        ack_q == (state_q == ST_ACK));

endmodule

// File: tb/tb_gumnut_data_mem_responder.sv
// tb/tb_gumnut_data_mem_responder.sv - self-checking bench for gumnut_data_mem_responder at WAIT_STATES 0, 1 and 3
module tb_gumnut_data_mem_responder;

    logic       clk = 1'b0;
    logic       rst, cyc, stb, we;
    logic [7:0] adr, dat;

    always #5 clk = ~clk;

    gumnut_data_mem_responder_if #(.ADDR_W(8)) bus0 ();
    gumnut_data_mem_responder_if #(.ADDR_W(8)) bus1 ();
    gumnut_data_mem_responder_if #(.ADDR_W(8)) bus2 ();

    assign bus0.data_cyc_i = cyc; assign bus0.data_stb_i = stb; assign bus0.data_we_i = we;
    assign bus0.data_adr_i = adr; assign bus0.data_dat_i = dat;
    assign bus1.data_cyc_i = cyc; assign bus1.data_stb_i = stb; assign bus1.data_we_i = we;
    assign bus1.data_adr_i = adr; assign bus1.data_dat_i = dat;
    assign bus2.data_cyc_i = cyc; assign bus2.data_stb_i = stb; assign bus2.data_we_i = we;
    assign bus2.data_adr_i = adr; assign bus2.data_dat_i = dat;

    gumnut_data_mem_responder #(.ADDR_W(8), .WAIT_STATES(0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0.slave));
    gumnut_data_mem_responder #(.ADDR_W(8), .WAIT_STATES(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1.slave));
    gumnut_data_mem_responder #(.ADDR_W(8), .WAIT_STATES(3)) dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2.slave));

    logic       ack_w  [3];
    logic [7:0] dout_w [3];
    assign ack_w[0] = bus0.data_ack_o; assign dout_w[0] = bus0.data_dat_o;
    assign ack_w[1] = bus1.data_ack_o; assign dout_w[1] = bus1.data_dat_o;
    assign ack_w[2] = bus2.data_ack_o; assign dout_w[2] = bus2.data_dat_o;

    int nvec = 0;
    int nerr = 0;
    int ncyc = 0;

    // Reference: a request accepted in cycle n is acknowledged in cycle n+1+ws
    // unless cyc&stb is missing in any cycle before that or reset intervenes.
    bit         m_pend [3];
    bit         m_ack  [3];
    int         m_due  [3];
    bit         m_we   [3];
    logic [7:0] m_adr  [3];
    logic [7:0] m_dat  [3];
    logic [7:0] m_dout [3];
    logic [7:0] m_mem  [3][256];

    function automatic int ws_of(input int k);
        case (k)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input bit ok, input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, k, ncyc, act, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_pend[k] = 1'b0; m_ack[k] = 1'b0; m_dout[k] = 8'h00;
            end else if (m_ack[k]) begin
                m_ack[k] = 1'b0;
            end else begin
                if (!m_pend[k]) begin
                    if (cyc && stb) begin
                        m_pend[k] = 1'b1; m_we[k] = we; m_adr[k] = adr; m_dat[k] = dat;
                        m_due[k]  = ncyc + 1 + ws_of(k);
                    end
                end else if (!(cyc && stb)) begin
                    m_pend[k] = 1'b0;
                end
                if (m_pend[k] && m_due[k] == ncyc + 1) begin
                    if (m_we[k]) m_mem[k][m_adr[k]] = m_dat[k];
                    else         m_dout[k] = m_mem[k][m_adr[k]];
                    m_ack[k]  = 1'b1;
                    m_pend[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        ncyc++;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk(ack_w[k] === m_ack[k], "model_ack", k, 32'(ack_w[k]), 32'(m_ack[k]));
            chk(dout_w[k] === m_dout[k], "model_dout", k, 32'(dout_w[k]), 32'(m_dout[k]));
        end
    endtask

    typedef struct {
        int         dut;
        bit         we;
        logic [7:0] adr;
        logic [7:0] dat;
        int         ev_at;    // cycle after request at which the event is applied
        int         ev_kind;  // 0 none, 1 drop stb, 2 reset pulse, 3 move adr/dat
        bit         exp_ack;
        logic [7:0] exp_rd;
    } txn_t;

    task automatic run_txn(input txn_t t);
        bit got;
        int lat;
        got = 1'b0; lat = 0;
        cyc = 1'b1; stb = 1'b1; we = t.we; adr = t.adr; dat = t.dat;
        for (int i = 1; i <= 10 && !got; i++) begin
            tick();
            if (rst) begin
                rst = 1'b0;
                chk(dout_w[t.dut] === 8'h00, "rst_dout", t.dut, 32'(dout_w[t.dut]), 32'h0);
                chk(ack_w[t.dut] === 1'b0, "rst_ack", t.dut, 32'(ack_w[t.dut]), 32'h0);
            end
            if (ack_w[t.dut]) begin
                got = 1'b1; lat = i;
                if (!t.we)
                    chk(dout_w[t.dut] === t.exp_rd, "tbl_rdata", t.dut, 32'(dout_w[t.dut]), 32'(t.exp_rd));
            end else if (i == t.ev_at) begin
                case (t.ev_kind)
                    1: begin cyc = 1'b0; stb = 1'b0; end
                    2: begin rst = 1'b1; cyc = 1'b0; stb = 1'b0; end
                    3: begin adr = 8'hFF; dat = 8'h99; end
                    default: ;
                endcase
            end
        end
        cyc = 1'b0; stb = 1'b0;
        tick();
        chk(got == t.exp_ack, "tbl_ack_seen", t.dut, 32'(got), 32'(t.exp_ack));
        if (got && t.exp_ack)
            chk(lat == 1 + ws_of(t.dut), "tbl_latency", t.dut, 32'(lat), 32'(1 + ws_of(t.dut)));
    endtask

    txn_t tbl[$];

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_pend[k] = 1'b0; m_ack[k] = 1'b0; m_dout[k] = 8'h00; m_due[k] = 0;
            for (int a = 0; a < 256; a++) m_mem[k][a] = 8'hxx;
        end
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 8'h00; dat = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk(ack_w[k] === 1'b0, "reset_ack", k, 32'(ack_w[k]), 32'h0);
            chk(dout_w[k] === 8'h00, "reset_dout", k, 32'(dout_w[k]), 32'h0);
        end

        // Clear every RAM location so that all later reads have a known answer.
        for (int a = 0; a < 256; a++) begin
            cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'(a); dat = 8'h00;
            repeat (4) tick();
            cyc = 1'b0; stb = 1'b0;
            tick();
        end

        tbl.push_back('{1, 1'b1, 8'h10, 8'hA5, 0, 0, 1'b1, 8'h00});
        tbl.push_back('{1, 1'b0, 8'h10, 8'h00, 0, 0, 1'b1, 8'hA5});
        tbl.push_back('{0, 1'b0, 8'h10, 8'h00, 0, 0, 1'b1, 8'hA5});
        tbl.push_back('{2, 1'b1, 8'h20, 8'h3C, 2, 1, 1'b0, 8'h00});
        tbl.push_back('{2, 1'b0, 8'h20, 8'h00, 0, 0, 1'b1, 8'h00});
        tbl.push_back('{2, 1'b1, 8'h30, 8'h11, 1, 3, 1'b1, 8'h00});
        tbl.push_back('{2, 1'b0, 8'h30, 8'h00, 0, 0, 1'b1, 8'h11});
        tbl.push_back('{2, 1'b1, 8'h40, 8'h77, 2, 2, 1'b0, 8'h00});
        tbl.push_back('{2, 1'b0, 8'h40, 8'h00, 0, 0, 1'b1, 8'h00});
        tbl.push_back('{2, 1'b0, 8'hFF, 8'h00, 0, 0, 1'b1, 8'h00});
        tbl.push_back('{1, 1'b1, 8'hFF, 8'h5A, 0, 0, 1'b1, 8'h00});
        tbl.push_back('{1, 1'b1, 8'h00, 8'hC3, 0, 0, 1'b1, 8'h00});
        tbl.push_back('{1, 1'b0, 8'hFF, 8'h00, 0, 0, 1'b1, 8'h5A});
        tbl.push_back('{1, 1'b0, 8'h00, 8'h00, 0, 0, 1'b1, 8'hC3});
        tbl.push_back('{0, 1'b0, 8'hFF, 8'h00, 0, 0, 1'b1, 8'h5A});
        tbl.push_back('{0, 1'b0, 8'h00, 8'h00, 0, 0, 1'b1, 8'hC3});
        for (int i = 0; i < tbl.size(); i++) run_txn(tbl[i]);

        // Zero-wait responder with strobe held: ack, gap, ack again.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h10; dat = 8'h00;
        tick();
        chk(ack_w[0] === 1'b1, "b2b_ack1", 0, 32'(ack_w[0]), 32'h1);
        chk(dout_w[0] === 8'hA5, "b2b_dout1", 0, 32'(dout_w[0]), 32'hA5);
        tick();
        chk(ack_w[0] === 1'b0, "b2b_gap", 0, 32'(ack_w[0]), 32'h0);
        tick();
        chk(ack_w[0] === 1'b1, "b2b_ack2", 0, 32'(ack_w[0]), 32'h1);
        chk(dout_w[0] === 8'hA5, "b2b_dout2", 0, 32'(dout_w[0]), 32'hA5);
        cyc = 1'b0; stb = 1'b0;
        tick();

        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            cyc = ($urandom_range(0, 7) != 0);
            stb = ($urandom_range(0, 5) != 0);
            we  = $urandom_range(0, 1) == 1;
            adr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            dat = 8'($urandom);
            tick();
        end
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/gumnut_data_mem_responder.md
Name: gumnut_data_mem_responder

Overview:
- Wishbone-classic responder (slave) for the Gumnut data-memory port.
- Sits on the far side of the processing unit's data bus: it receives the data-port request (cyc/stb/we/adr/dat) and returns read data on data_dat_o with a data_ack_o handshake.
- Holds a 2^ADDR_W x 8 synchronous data RAM and inserts a programmable number of wait states before acknowledging each access.

Parameters:
- ADDR_W, 8, address width; memory depth is 2^ADDR_W bytes.
- WAIT_STATES, 1, extra cycles between request capture and ack; legal range 0..15.

Ports:
- clk_i  input  1  system clock; all state changes on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- data_cyc_i  input  1  bus cycle in progress.
- data_stb_i  input  1  strobe; a request is valid when cyc&stb are both 1.
- data_we_i  input  1  1 = write, 0 = read.
- data_adr_i  input  ADDR_W  byte address.
- data_dat_i  input  8  write data from the processor.
- data_dat_o  output  8  read data returned to the processor (feeds the processor's data_dat_i).
- data_ack_o  output  1  single-cycle transfer acknowledge (feeds the processor's data ack).

Behaviour:
- Reset (rst_i=1 at an edge):
  - state→IDLE; data_ack_o=0; data_dat_o=8'h00; wait counter=0.
  - Any pending, uncommitted write is dropped.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - At an edge with cyc&stb=1, latch adr, we and dat into internal registers; load the counter with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, else ACK.
  - Otherwise remain in IDLE.
- WAIT:
  - Decrement the counter every edge; when the counter reaches 1 (the last wait cycle), next state is ACK.
  - If cyc or stb is sampled 0 in WAIT, abort: next state IDLE, no ack, no RAM write.
- ACK:
  - data_ack_o=1 for exactly this one cycle.
  - Next state is always IDLE.
  - data_ack_o is registered, high only in ACK, never combinational from inputs.
- Latency:
  - Request first presented in cycle c → data_ack_o high in cycle c+1+WAIT_STATES.
  - WAIT_STATES=0 gives ack in cycle c+1.
- Write commit:
  - mem[latched adr] ← latched dat at the edge that enters ACK.
  - Write data is taken from the capture latch, not from the live data_dat_i.
- Read data:
  - At the edge entering ACK on a read, data_dat_o ← mem[latched adr]; valid while ack=1.
  - data_dat_o holds its last read value at all other times; writes do not change data_dat_o.
- Read-after-write to the same address in the following transaction returns the new value.
- Back-to-back requests:
  - ACK→IDLE is mandatory, so there is a minimum of one idle cycle between acks.
  - If cyc&stb is still 1 in IDLE, a new transaction is captured (the master must drop stb after ack to avoid a repeat).
- Address changes during WAIT are ignored; the latched address governs.
- Reset asserted in WAIT or ACK: the next cycle is IDLE, ack=0, and no write is committed if reset coincides with the ACK-entry edge.
- The counter is 4 bits; WAIT_STATES>15 is illegal (elaboration assertion).

Test Plan:
- WAIT_STATES=1: write adr 8'h10 dat 8'hA5 (cyc=stb=we=1 in cycle 0) → ack=1 in cycle 2 only. Then read adr 8'h10 → ack 2 cycles after request, data_dat_o=8'hA5 during ack.
- WAIT_STATES=0: read 8'h10 presented in cycle c → ack in cycle c+1, data_dat_o=8'hA5; ack deasserts in cycle c+2 with stb still high, and a second ack follows in cycle c+3.
- WAIT_STATES=3: write 8'h20←8'h3C, drop stb after 1 wait cycle → no ack ever. A subsequent read of 8'h20 returns the prior contents (pre-written 8'h00), not 8'h3C.
- Change data_adr_i and data_dat_i to 8'hFF/8'h99 during WAIT of a write to 8'h30←8'h11 → mem[8'h30]=8'h11, mem[8'hFF] unchanged.
- Assert rst_i for one cycle during WAIT of a write to 8'h40←8'h77 → ack stays 0, data_dat_o=8'h00, state IDLE; a later read of 8'h40 does not return 8'h77.
- Address wrap: write 8'hFF←8'h5A then 8'h00←8'hC3, read both → 8'h5A and 8'hC3 respectively, no aliasing.
